// File: rtl/eth_arb_pkg.sv
// Shared definitions for the Ethernet frame arbiters: FSM state encoding and
// the width of the completed-frame counter.
package eth_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int FRAME_CNT_W = 16;

endpackage : eth_arb_pkg

// File: rtl/rr_prio_select.sv
// Cyclic priority search: returns the first set mask bit at or after ptr+1,
// wrapping round so that ptr itself is considered last.
module rr_prio_select #(
   parameter int PORTS    = 4,
   parameter int CL_PORTS = $clog2(PORTS)
) (
   input  logic [PORTS-1:0]    i_mask,
   input  logic [CL_PORTS-1:0] i_ptr,
   output logic                o_found,
   output logic [CL_PORTS-1:0] o_index
);

   localparam logic [CL_PORTS:0] PORTS_W = (CL_PORTS+1)'(PORTS);

   logic [CL_PORTS:0]   w_shift;
   logic [PORTS-1:0]    w_rot;
   logic [CL_PORTS-1:0] w_k;
   logic [CL_PORTS:0]   w_sum;

   // Doubling the mask turns the cyclic rotate into a plain right shift.
   assign w_shift = {1'b0, i_ptr} + {{CL_PORTS{1'b0}}, 1'b1};
   assign w_rot   = PORTS'({i_mask, i_mask} >> w_shift);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_found = 1'b0;
      w_k     = '0;
      for (int i = PORTS-1; i >= 0; i--) begin
         if (w_rot[i]) begin
            o_found = 1'b1;
            w_k     = CL_PORTS'(i);
         end
      end
      w_sum = {1'b0, w_k} + w_shift;
      if (w_sum >= PORTS_W) o_index = CL_PORTS'(w_sum - PORTS_W);
      else                  o_index = w_sum[CL_PORTS-1:0];
   end

endmodule : rr_prio_select

// File: rtl/eth_wrr_arbiter.sv
// Frame-level weighted round-robin arbiter: a port keeps the grant for up to
// weight[i] consecutive frames before the grant rotates to the next requester.
module eth_wrr_arbiter
   import eth_arb_pkg::*;
#(
   parameter int PORTS        = 4,
   parameter int WEIGHT_WIDTH = 4,
   parameter int CL_PORTS     = $clog2(PORTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS-1:0]              request,
   input  logic [PORTS-1:0]              acknowledge,
   input  logic [PORTS*WEIGHT_WIDTH-1:0] cfg_weight,
   input  logic                          cfg_update,
   output logic [PORTS-1:0]              grant,
   output logic                          grant_valid,
   output logic [CL_PORTS-1:0]           grant_encoded,
   output logic [FRAME_CNT_W-1:0]        frames_granted
);

   localparam logic [PORTS-1:0]        ONE_HOT0   = PORTS'(1);
   localparam logic [WEIGHT_WIDTH-1:0] WEIGHT_RST = WEIGHT_WIDTH'(1);

   arb_state_e              r_state;
   logic [WEIGHT_WIDTH-1:0] r_weight [PORTS];
   logic [WEIGHT_WIDTH-1:0] r_credit [PORTS];
   logic [CL_PORTS-1:0]     r_ptr;
   logic [PORTS-1:0]        r_grant;
   logic                    r_grant_valid;
   logic [CL_PORTS-1:0]     r_grant_encoded;
   logic [FRAME_CNT_W-1:0]  r_frames;

   logic [PORTS-1:0]        w_cand;
   logic                    w_stay;
   logic                    w_found;
   logic [CL_PORTS-1:0]     w_idx;
   logic                    w_ack;

   // A zero-weight port is disabled: it never enters the rotate search.
   always_comb begin
      w_cand = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_cand[i] = request[i] && (r_weight[i] != '0);
      end
   end

   assign w_stay = request[r_ptr] && (r_weight[r_ptr] != '0) && (r_credit[r_ptr] != '0);
   assign w_ack  = |(acknowledge & r_grant);

   rr_prio_select #(
      .PORTS    (PORTS),
      .CL_PORTS (CL_PORTS)
   ) u_prio (
      .i_mask  (w_cand),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_index (w_idx)
   );

   // NOTE: all state here is sequential, so it is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ARB_IDLE;
         // NOTE: weights and credits are a handful of flops whose reset value is functional, so they are reset.
         for (int i = 0; i < PORTS; i++) begin
            r_weight[i] <= WEIGHT_RST;
            r_credit[i] <= '0;
         end
         r_ptr           <= CL_PORTS'(PORTS-1);
         r_grant         <= '0;
         r_grant_valid   <= 1'b0;
         r_grant_encoded <= '0;
         r_frames        <= '0;
      end else begin
         if (cfg_update) begin
            for (int i = 0; i < PORTS; i++) begin
               r_weight[i] <= cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
         end

         case (r_state)
            ARB_IDLE: begin
               if (w_stay) begin
                  r_grant         <= ONE_HOT0 << r_ptr;
                  r_grant_encoded <= r_ptr;
                  r_grant_valid   <= 1'b1;
                  r_state         <= ARB_BUSY;
               end else if (w_found) begin
                  // Rotate-in reloads credit from the weight in force before any same-cycle update.
                  r_grant         <= ONE_HOT0 << w_idx;
                  r_grant_encoded <= w_idx;
                  r_grant_valid   <= 1'b1;
                  r_ptr           <= w_idx;
                  r_credit[w_idx] <= r_weight[w_idx];
                  r_state         <= ARB_BUSY;
               end
            end

            ARB_BUSY: begin
               if (w_ack) begin
                  if (r_credit[r_grant_encoded] != '0) begin
                     r_credit[r_grant_encoded] <= r_credit[r_grant_encoded] - WEIGHT_WIDTH'(1);
                  end
                  r_frames      <= r_frames + FRAME_CNT_W'(1);
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_state       <= ARB_IDLE;
               end
            end

            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign grant          = r_grant;
   assign grant_valid    = r_grant_valid;
   assign grant_encoded  = r_grant_encoded;
   assign frames_granted = r_frames;

endmodule : eth_wrr_arbiter
